// File: rtl/cache_control.sv
// cache_control: sequencing FSM for a 2-way set-associative cache, with Mealy strobes,
// pmem writeback/allocate sequencing and saturating hit/miss counters.
module cache_control #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_read,
  input  logic             mem_write,
  output logic             mem_resp,
  input  logic             hit0,
  input  logic             hit1,
  input  logic             lru,
  input  logic             dirty0,
  input  logic             dirty1,
  input  logic             pmem_resp,
  output logic             pmem_read,
  output logic             pmem_write,
  output logic             pmem_addr_sel,
  output logic             data_in_sel,
  output logic             way_sel,
  output logic [1:0]       load_data,
  output logic [1:0]       load_tag,
  output logic [1:0]       set_valid,
  output logic [1:0]       set_dirty,
  output logic [1:0]       clear_dirty,
  output logic             load_lru,
  output logic             lru_in,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);
  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_e;
  state_e state_q, state_d;
  logic victim_q, victim_d;
  logic [CNT_W-1:0] hit_q, hit_d, miss_q, miss_d;
  logic req, hit, hitway;
  logic [1:0] hit_mask, vic_mask;
  assign req = mem_read | mem_write;
  assign hit = hit0 | hit1;
  assign hitway = ~hit0;
  assign hit_mask = hitway ? 2'b10 : 2'b01;
  assign vic_mask = victim_q ? 2'b10 : 2'b01;
  assign hit_count = hit_q;
  assign miss_count = miss_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      victim_q <= 1'b0;
      hit_q    <= '0;
      miss_q   <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
    end
  end
  // Strobes are forced low during reset so pmem sees the abort immediately.
  always_comb begin
    state_d       = state_q;
    victim_d      = victim_q;
    hit_d         = hit_q;
    miss_d        = miss_q;
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_addr_sel = 1'b0;
    data_in_sel   = 1'b0;
    way_sel       = 1'b0;
    load_data     = 2'b00;
    load_tag      = 2'b00;
    set_valid     = 2'b00;
    set_dirty     = 2'b00;
    clear_dirty   = 2'b00;
    load_lru      = 1'b0;
    lru_in        = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (req && hit) begin
            mem_resp  = 1'b1;
            way_sel   = hitway;
            load_lru  = 1'b1;
            lru_in    = ~hitway;
            load_data = mem_write ? hit_mask : 2'b00;
            set_dirty = mem_write ? hit_mask : 2'b00;
            hit_d     = &hit_q ? hit_q : hit_q + CNT_W'(1);
          end else if (req) begin
            victim_d = lru;
            miss_d   = &miss_q ? miss_q : miss_q + CNT_W'(1);
            state_d  = (lru ? dirty1 : dirty0) ? WRITEBACK : ALLOCATE;
          end
        end
        WRITEBACK: begin
          pmem_write    = 1'b1;
          pmem_addr_sel = 1'b1;
          way_sel       = victim_q;
          clear_dirty   = pmem_resp ? vic_mask : 2'b00;
          state_d       = pmem_resp ? ALLOCATE : WRITEBACK;
        end
        ALLOCATE: begin
          pmem_read   = 1'b1;
          load_data   = pmem_resp ? vic_mask : 2'b00;
          load_tag    = pmem_resp ? vic_mask : 2'b00;
          set_valid   = pmem_resp ? vic_mask : 2'b00;
          data_in_sel = pmem_resp;
          state_d     = pmem_resp ? IDLE : ALLOCATE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_control.sv
// tb_cache_control: directed and random stimulus against a transaction-level model
// that keeps a queue of pending pmem operations per miss.
module tb_cache_control;
  localparam int CW = 4;
  localparam int MAXC = (1 << CW) - 1;
  logic clk = 0, reset = 1;
  logic mem_read = 0, mem_write = 0, hit0 = 0, hit1 = 0, lru = 0, dirty0 = 0, dirty1 = 0, pmem_resp = 0;
  logic mem_resp, pmem_read, pmem_write, pmem_addr_sel, data_in_sel, way_sel, load_lru, lru_in;
  logic [1:0] load_data, load_tag, set_valid, set_dirty, clear_dirty;
  logic [CW-1:0] hit_count, miss_count;
  int checks = 0, fails = 0;
  int m_hits = 0, m_misses = 0, m_vic = 0;
  bit ops[$];
  always #5 clk = ~clk;
  cache_control #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
    .hit0(hit0), .hit1(hit1), .lru(lru), .dirty0(dirty0), .dirty1(dirty1), .pmem_resp(pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr_sel(pmem_addr_sel),
    .data_in_sel(data_in_sel), .way_sel(way_sel), .load_data(load_data), .load_tag(load_tag),
    .set_valid(set_valid), .set_dirty(set_dirty), .clear_dirty(clear_dirty), .load_lru(load_lru),
    .lru_in(lru_in), .hit_count(hit_count), .miss_count(miss_count)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic compare_all();
    logic e_resp = 0, e_pr = 0, e_pw = 0, e_pas = 0, e_dis = 0, e_way = 0, e_ll = 0, e_li = 0;
    logic [1:0] e_ld = 0, e_lt = 0, e_sv = 0, e_sd = 0, e_cd = 0;
    logic [1:0] vm = (m_vic == 1) ? 2'b10 : 2'b01;
    int hw = hit0 ? 0 : 1;
    logic [1:0] hm = (hw == 1) ? 2'b10 : 2'b01;
    if (reset) begin
    end else if (ops.size() == 0) begin
      if ((mem_read || mem_write) && (hit0 || hit1)) begin
        e_resp = 1; e_way = hw[0]; e_ll = 1; e_li = !hw[0];
        if (mem_write) begin e_ld = hm; e_sd = hm; end
      end
    end else if (ops[0]) begin
      e_pw = 1; e_pas = 1; e_way = m_vic[0];
      if (pmem_resp) e_cd = vm;
    end else begin
      e_pr = 1;
      if (pmem_resp) begin e_ld = vm; e_lt = vm; e_sv = vm; e_dis = 1; end
    end
    chk("mem_resp", 32'(mem_resp), 32'(e_resp));
    chk("pmem_read", 32'(pmem_read), 32'(e_pr));
    chk("pmem_write", 32'(pmem_write), 32'(e_pw));
    chk("pmem_addr_sel", 32'(pmem_addr_sel), 32'(e_pas));
    chk("data_in_sel", 32'(data_in_sel), 32'(e_dis));
    chk("way_sel", 32'(way_sel), 32'(e_way));
    chk("load_data", 32'(load_data), 32'(e_ld));
    chk("load_tag", 32'(load_tag), 32'(e_lt));
    chk("set_valid", 32'(set_valid), 32'(e_sv));
    chk("set_dirty", 32'(set_dirty), 32'(e_sd));
    chk("clear_dirty", 32'(clear_dirty), 32'(e_cd));
    chk("load_lru", 32'(load_lru), 32'(e_ll));
    chk("lru_in", 32'(lru_in), 32'(e_li));
    chk("hit_count", 32'(hit_count), 32'(m_hits));
    chk("miss_count", 32'(miss_count), 32'(m_misses));
  endtask
  task automatic model_update();
    if (ops.size() == 0) begin
      if ((mem_read || mem_write) && (hit0 || hit1)) m_hits = (m_hits < MAXC) ? m_hits + 1 : MAXC;
      else if (mem_read || mem_write) begin
        m_misses = (m_misses < MAXC) ? m_misses + 1 : MAXC;
        m_vic = int'(lru);
        if (lru ? dirty1 : dirty0) ops.push_back(1'b1);
        ops.push_back(1'b0);
      end
    end else if (pmem_resp) void'(ops.pop_front());
  endtask
  task automatic model_reset();
    ops.delete();
    m_hits = 0; m_misses = 0; m_vic = 0;
  endtask
  task automatic cyc(input logic mr, mw, h0, h1, l, d0, d1, pr);
    mem_read = mr; mem_write = mw; hit0 = h0; hit1 = h1; lru = l; dirty0 = d0; dirty1 = d1; pmem_resp = pr;
    #1 compare_all();
    @(posedge clk);
    model_update();
    #1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 compare_all();
    reset = 0;
    // read hit in way1
    cyc(1, 0, 0, 1, 0, 0, 0, 0);
    chk("hit_after_first", 32'(hit_count), 32'd1);
    // write hit in way0
    cyc(0, 1, 1, 0, 1, 0, 0, 0);
    // read miss, lru=1 clean, pmem_resp after 5 cycles, then hit
    cyc(1, 0, 0, 0, 1, 0, 0, 0);
    repeat (4) cyc(1, 0, 0, 0, 1, 0, 0, 0);
    chk("rd_miss_pmem_read", 32'(pmem_read), 32'd1);
    cyc(1, 0, 0, 0, 1, 0, 0, 1);
    cyc(1, 0, 0, 1, 0, 0, 0, 0);
    chk("miss_after_rd", 32'(miss_count), 32'd1);
    // write miss, lru=0 dirty0, lru toggles during the miss
    cyc(0, 1, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, i[0], 1, 1, 0);
    cyc(0, 1, 0, 0, 1, 1, 1, 1);
    cyc(0, 1, 0, 0, 1, 0, 1, 0);
    cyc(0, 1, 0, 0, 1, 0, 1, 1);
    cyc(0, 1, 1, 0, 1, 0, 0, 0);
    // reset two cycles into writeback
    cyc(0, 1, 0, 0, 1, 0, 1, 0);
    cyc(0, 1, 0, 0, 1, 0, 1, 0);
    cyc(0, 1, 0, 0, 1, 0, 1, 0);
    #2 reset = 1;
    model_reset();
    #1 compare_all();
    chk("rst_pmem_write", 32'(pmem_write), 32'd0);
    @(posedge clk);
    #2 reset = 0;
    mem_read = 0; mem_write = 0;
    @(posedge clk);
    #1;
    repeat (3) cyc(0, 0, 0, 0, 1, 1, 1, 1);
    // saturation
    for (int i = 0; i < 20; i++) cyc(1, 0, i[0], !i[0], 0, 0, 0, 0);
    chk("hit_sat", 32'(hit_count), 32'(MAXC));
    // random
    for (int i = 0; i < 600; i++) begin
      logic rq = ($urandom_range(0, 9) < 8);
      logic w = $urandom_range(0, 1);
      cyc(rq & !w, rq & w, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3,
          $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 9) < 3);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
